// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use stall,
// branch redirect flush, multi-cycle EX freeze. Optional perf counters via HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MC_TIMEOUT      = 64,
  parameter int REDIRECT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       ex_mc_start,
  input  logic       mc_done,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_regwrite,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_bubble,
  output logic       mc_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mc_stalls,
  output logic [31:0] perf_flushes
`endif
);

  localparam int MC_W = $clog2(MC_TIMEOUT + 1);
  localparam int RD_W = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES + 1) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);
  localparam logic [RD_W-1:0] RD_INIT = RD_W'(REDIRECT_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_ONE  = RD_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t          r_state;
  logic [MC_W-1:0] r_mc_cnt;
  logic [RD_W-1:0] r_rd_cnt;

  logic w_in_run, w_in_mc, w_in_rd;
  logic w_load_use, w_run_branch, w_run_mc_enter, w_run_lu;
  logic w_mc_hold, w_mc_timeout, w_mc_stall;

  // MEM/WB result selection; x0 is hard-wired zero so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] m_rd,
                                         input logic m_we, input logic [4:0] w_rd,
                                         input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))      return 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Encoding 3 is unused and behaves as RUN.
  assign w_in_mc  = (r_state == ST_MC_WAIT);
  assign w_in_rd  = (r_state == ST_REDIRECT);
  assign w_in_run = !w_in_mc && !w_in_rd;

  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign w_run_branch   = w_in_run && ex_branch_taken;
  assign w_run_mc_enter = w_in_run && !ex_branch_taken && ex_mc_start && !mc_done;
  assign w_run_lu       = w_in_run && !ex_branch_taken && !ex_mc_start && w_load_use;
  assign w_mc_timeout   = w_in_mc && !mc_done && (r_mc_cnt == MC_LAST);
  assign w_mc_hold      = w_in_mc && !mc_done && (r_mc_cnt != MC_LAST);
  assign w_mc_stall     = w_run_mc_enter || w_mc_hold;

  always_comb begin
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mc_timeout   = 1'b0;
    if (!reset) begin
      fwd_a        = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b        = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      pc_stall     = w_mc_stall || w_run_lu;
      ifid_stall   = w_mc_stall || w_run_lu;
      idex_stall   = w_mc_stall;
      exmem_bubble = w_mc_stall;
      ifid_flush   = w_run_branch || w_in_rd;
      idex_flush   = w_run_branch || w_run_lu;
      mc_timeout   = w_mc_timeout;
    end
  end

  assign ctrl_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        ST_MC_WAIT: begin
          if (mc_done || (r_mc_cnt == MC_LAST)) begin
            r_state  <= ST_RUN;
            r_mc_cnt <= '0;
          end else begin
            r_mc_cnt <= r_mc_cnt + 1'b1;
          end
        end
        ST_REDIRECT: begin
          r_rd_cnt <= r_rd_cnt - 1'b1;
          if (r_rd_cnt == RD_ONE) r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
          if (ex_branch_taken) begin
            if (REDIRECT_CYCLES > 1) begin
              r_state  <= ST_REDIRECT;
              r_rd_cnt <= RD_INIT;
            end
          end else if (ex_mc_start && !mc_done) begin
            r_state  <= ST_MC_WAIT;
            r_mc_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_stalls <= '0;
      perf_mc_stalls <= '0;
      perf_flushes   <= '0;
    end else begin
      if (w_run_lu)     perf_lu_stalls <= sat_inc(perf_lu_stalls);
      if (w_mc_stall)   perf_mc_stalls <= sat_inc(perf_mc_stalls);
      if (w_run_branch) perf_flushes   <= sat_inc(perf_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MC_TIMEOUT=8, REDIRECT_CYCLES=3).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, ex_mc_start, mc_done;
  logic       mem_regwrite, wb_regwrite;
  logic [1:0] fwd_a, fwd_b, ctrl_state;
  logic       pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, mc_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_mc_stalls, perf_flushes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .REDIRECT_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_stall(idex_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .mc_timeout(mc_timeout), .ctrl_state(ctrl_state)
`ifdef HAZ_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_mc_stalls(perf_mc_stalls), .perf_flushes(perf_flushes)
`endif
  );

  // {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, mc_timeout}
  logic [6:0] ctl;
  assign ctl = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble, mc_timeout};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MC   = 7'b1110010;
  localparam logic [6:0] C_BR   = 7'b0001100;
  localparam logic [6:0] C_RD   = 7'b0001000;
  localparam logic [6:0] C_TO   = 7'b0000001;

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    n_tests++;
    assert (ctl === exp) else begin
      n_fail++;
      $error("FAIL %s: ctl observed %b expected %b", tag, ctl, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    n_tests++;
    assert (ctrl_state === exp) else begin
      n_fail++;
      $error("FAIL %s: ctrl_state observed %0d expected %0d", tag, ctrl_state, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    n_tests++;
    assert ({fwd_a, fwd_b} === {ea, eb}) else begin
      n_fail++;
      $error("FAIL %s: fwd_a/fwd_b observed %b/%b expected %b/%b", tag, fwd_a, fwd_b, ea, eb);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    mem_rd = 5'd3; mem_regwrite = 1'b1; ex_rs1 = 5'd3;
    ex_rd = 5'd5; ex_memread = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    next_cycle(); #1;
    chk_ctl("reset_ctl", C_NONE);
    chk_state("reset_state", 2'd0);
    chk_fwd("reset_fwd", 2'b00, 2'b00);
    next_cycle();
    reset = 1'b0;
    clear_inputs();

    // Forwarding
    next_cycle();
    mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1; ex_rs1 = 5'd3; ex_rs2 = 5'd7;
    #1 chk_fwd("fwd_mem_prio", 2'b10, 2'b00);
    mem_regwrite = 1'b0;
    #1 chk_fwd("fwd_wb", 2'b01, 2'b00);
    ex_rs1 = 5'd0;
    #1 chk_fwd("fwd_x0_src", 2'b00, 2'b00);
    mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd9; ex_rs1 = 5'd0; ex_rs2 = 5'd9;
    #1 chk_fwd("fwd_b_wb_memx0", 2'b00, 2'b01);
    mem_rd = 5'd9;
    #1 chk_fwd("fwd_b_mem", 2'b00, 2'b10);
    chk_ctl("fwd_no_ctl", C_NONE);
    clear_inputs();

    // Load-use
    next_cycle();
    ex_rd = 5'd5; ex_memread = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1 chk_ctl("lu_rs1", C_LU);
    next_cycle();
    ex_memread = 1'b0;
    #1 chk_ctl("lu_resolved", C_NONE);
    chk_state("lu_state", 2'd0);
    next_cycle();
    ex_memread = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b0; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 chk_ctl("lu_rs2", C_LU);
    id_uses_rs2 = 1'b0;
    #1 chk_ctl("lu_unused_src", C_NONE);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1 chk_ctl("lu_x0", C_NONE);
    clear_inputs();

    // Multi-cycle op finishing after 5 cycles
    next_cycle();
    ex_mc_start = 1'b1;
    #1 chk_ctl("mc_entry", C_MC);
    chk_state("mc_entry_state", 2'd0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      ex_mc_start = 1'b0;
      ex_branch_taken = (i == 2);
      #1 chk_ctl($sformatf("mc_wait%0d", i), C_MC);
      chk_state($sformatf("mc_wait_state%0d", i), 2'd1);
    end
    next_cycle();
    ex_branch_taken = 1'b0; mc_done = 1'b1;
    #1 chk_ctl("mc_done_cycle", C_NONE);
    chk_state("mc_done_state", 2'd1);
    next_cycle();
    mc_done = 1'b0;
    #1 chk_state("mc_back_run", 2'd0);
    chk_ctl("mc_after", C_NONE);

    // Start and done in the same cycle
    ex_mc_start = 1'b1; mc_done = 1'b1;
    #1 chk_ctl("mc_same_cycle", C_NONE);
    next_cycle();
    clear_inputs();
    #1 chk_state("mc_same_state", 2'd0);

    // Timeout with MC_TIMEOUT=8
    next_cycle();
    ex_mc_start = 1'b1;
    #1 chk_ctl("to_entry", C_MC);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      ex_mc_start = 1'b0;
      #1 chk_ctl($sformatf("to_wait%0d", k), C_MC);
    end
    next_cycle();
    #1 chk_ctl("to_pulse", C_TO);
    chk_state("to_pulse_state", 2'd1);
    next_cycle();
    #1 chk_ctl("to_after", C_NONE);
    chk_state("to_run", 2'd0);

    // Branch with simultaneous load-use, REDIRECT_CYCLES=3
    next_cycle();
    ex_branch_taken = 1'b1; ex_rd = 5'd5; ex_memread = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1 chk_ctl("br_cycle", C_BR);
    for (int r = 1; r <= 2; r++) begin
      next_cycle();
      ex_branch_taken = 1'b0;
      #1 chk_ctl($sformatf("redirect%0d", r), C_RD);
      chk_state($sformatf("redirect_state%0d", r), 2'd2);
    end
    next_cycle();
    clear_inputs();
    #1 chk_ctl("br_done", C_NONE);
    chk_state("br_done_state", 2'd0);

    // Async reset in MC_WAIT cycle 2
    next_cycle();
    ex_mc_start = 1'b1;
    next_cycle();
    ex_mc_start = 1'b0;
    #1 chk_state("rst_mc_w1", 2'd1);
    next_cycle();
    #1 chk_ctl("rst_mc_w2", C_MC);
    #1 reset = 1'b1;
    #1 chk_ctl("rst_async_ctl", C_NONE);
    chk_state("rst_async_state", 2'd0);
    next_cycle();
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      next_cycle();
      #1 chk_ctl($sformatf("rst_no_to%0d", t), C_NONE);
    end
    chk_state("rst_final_state", 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
